// File: rtl/mulu_io_seq_pkg.sv
// Shared types and defaults for the mulu_io_seq byte-serial multiplier sequencer.
package mulu_io_seq_pkg;

   localparam int unsigned X_WIDTH_DEF   = 16;
   localparam int unsigned Y_WIDTH_DEF   = 16;
   localparam int unsigned P_WIDTH_DEF   = 32;
   localparam int unsigned BUS_WIDTH_DEF = 8;
   localparam int unsigned LATENCY_DEF   = 1;

   typedef enum logic [1:0] {
      LOAD_X  = 2'd0,
      LOAD_Y  = 2'd1,
      COMPUTE = 2'd2,
      UNLOAD  = 2'd3
   } state_t;

   function automatic int unsigned beats(input int unsigned width, input int unsigned bus);
      return width / bus;
   endfunction

endpackage

// File: rtl/mulu_io_seq_shreg.sv
// BUS_WIDTH-step right shift register with parallel load; q_o exposes the low OUT_WIDTH bits.
module mulu_io_shreg
   import mulu_io_seq_pkg::*;
#(
   parameter int unsigned WIDTH     = X_WIDTH_DEF,
   parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF,
   parameter int unsigned OUT_WIDTH = WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [WIDTH-1:0]     load_data_i,
   input  logic                 shift_i,
   input  logic [BUS_WIDTH-1:0] shift_in_i,
   output logic [OUT_WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q, q_d, shifted;

   if (WIDTH > BUS_WIDTH) begin : g_wide
      assign shifted = {shift_in_i, q_q[WIDTH-1:BUS_WIDTH]};
   end else begin : g_narrow
      assign shifted = WIDTH'(shift_in_i);
   end

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_data_i;
      end else if (shift_i) begin
         q_d = shifted;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/mulu_io_seq.sv
// Byte-serial operand/product sequencer around the unsigned multiplier.
// MULU_IO_RDY_EN adds mul_rdy and captures on it instead of after LATENCY cycles.
module mulu_io_seq
   import mulu_io_seq_pkg::*;
#(
   parameter int unsigned X_WIDTH   = X_WIDTH_DEF,
   parameter int unsigned Y_WIDTH   = Y_WIDTH_DEF,
   parameter int unsigned P_WIDTH   = P_WIDTH_DEF,
   parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF,
   parameter int unsigned LATENCY   = LATENCY_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BUS_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [X_WIDTH-1:0]   mul_x,
   output logic [Y_WIDTH-1:0]   mul_y,
   input  logic [P_WIDTH-1:0]   mul_p
`ifdef MULU_IO_RDY_EN
   ,
   input  logic                 mul_rdy
`endif
);

   localparam int unsigned XB     = beats(X_WIDTH, BUS_WIDTH);
   localparam int unsigned YB     = beats(Y_WIDTH, BUS_WIDTH);
   localparam int unsigned PB     = beats(P_WIDTH, BUS_WIDTH);
   localparam int unsigned CNT_W  = (PB > 1) ? $clog2(PB) : 1;
   localparam int unsigned WAIT_W = $clog2(LATENCY + 2);

   if (X_WIDTH % BUS_WIDTH != 0) begin : g_chk_x
      $error("X_WIDTH must be a multiple of BUS_WIDTH");
   end
   if (Y_WIDTH % BUS_WIDTH != 0) begin : g_chk_y
      $error("Y_WIDTH must be a multiple of BUS_WIDTH");
   end
   if (P_WIDTH != X_WIDTH + Y_WIDTH) begin : g_chk_p
      $error("P_WIDTH must equal X_WIDTH + Y_WIDTH");
   end

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [WAIT_W-1:0] wait_q;
   logic              out_valid_q;
   logic              x_shift, y_shift, p_shift, capture;

   assign in_ready  = (state_q == LOAD_X) || (state_q == LOAD_Y);
   assign busy      = (state_q == COMPUTE) || (state_q == UNLOAD);
   assign out_valid = out_valid_q;

   assign x_shift = (state_q == LOAD_X) && in_valid;
   assign y_shift = (state_q == LOAD_Y) && in_valid;
   assign p_shift = (state_q == UNLOAD) && out_valid_q && out_ready;

   // The entry cycle (wait_q == 0) never captures on mul_rdy, so a stale rdy is ignored.
`ifdef MULU_IO_RDY_EN
   assign capture = (state_q == COMPUTE) && mul_rdy && (wait_q != '0);
`else
   assign capture = (state_q == COMPUTE) && (wait_q == WAIT_W'(LATENCY));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD_X;
         cnt_q       <= '0;
         wait_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            LOAD_X: if (x_shift) begin
               if (cnt_q == CNT_W'(XB - 1)) begin
                  cnt_q   <= '0;
                  state_q <= LOAD_Y;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            LOAD_Y: if (y_shift) begin
               if (cnt_q == CNT_W'(YB - 1)) begin
                  cnt_q   <= '0;
                  wait_q  <= '0;
                  state_q <= COMPUTE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            COMPUTE: begin
               if (capture) begin
                  out_valid_q <= 1'b1;
                  state_q     <= UNLOAD;
               end else if (wait_q != '1) begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            UNLOAD: if (p_shift) begin
               if (cnt_q == CNT_W'(PB - 1)) begin
                  cnt_q       <= '0;
                  out_valid_q <= 1'b0;
                  state_q     <= LOAD_X;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= LOAD_X;
         endcase
      end
   end

   mulu_io_shreg #(.WIDTH(X_WIDTH), .BUS_WIDTH(BUS_WIDTH), .OUT_WIDTH(X_WIDTH)) u_x (
      .clk(clk), .rst_n(rst_n), .load_i(1'b0), .load_data_i('0),
      .shift_i(x_shift), .shift_in_i(in_data), .q_o(mul_x)
   );

   mulu_io_shreg #(.WIDTH(Y_WIDTH), .BUS_WIDTH(BUS_WIDTH), .OUT_WIDTH(Y_WIDTH)) u_y (
      .clk(clk), .rst_n(rst_n), .load_i(1'b0), .load_data_i('0),
      .shift_i(y_shift), .shift_in_i(in_data), .q_o(mul_y)
   );

   mulu_io_shreg #(.WIDTH(P_WIDTH), .BUS_WIDTH(BUS_WIDTH), .OUT_WIDTH(BUS_WIDTH)) u_p (
      .clk(clk), .rst_n(rst_n), .load_i(capture), .load_data_i(mul_p),
      .shift_i(p_shift), .shift_in_i('0), .q_o(out_data)
   );

endmodule

// File: tb/tb_mulu_io_seq.sv
// Randomized self-checking bench for mulu_io_seq against a plain x*y reference.
module tb_mulu_io_seq;

   localparam int unsigned XW  = 16;
   localparam int unsigned YW  = 16;
   localparam int unsigned PW  = 32;
   localparam int unsigned BW  = 8;
   localparam int unsigned LAT = 1;
   localparam int unsigned XB  = XW / BW;
   localparam int unsigned YB  = YW / BW;
   localparam int unsigned PB  = PW / BW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [BW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic [XW-1:0] mul_x;
   logic [YW-1:0] mul_y;
   logic [PW-1:0] mul_p;
`ifdef MULU_IO_RDY_EN
   logic          mul_rdy;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Combinational stand-in for the multiplier core.
   assign mul_p = PW'(mul_x) * PW'(mul_y);

   mulu_io_seq #(.X_WIDTH(XW), .Y_WIDTH(YW), .P_WIDTH(PW), .BUS_WIDTH(BW), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p)
`ifdef MULU_IO_RDY_EN
      , .mul_rdy(mul_rdy)
`endif
   );

   task automatic send_byte(input logic [BW-1:0] b);
      int t = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL send_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_ops(input logic [XW-1:0] x, input logic [YW-1:0] y, input bit gaps);
      for (int i = 0; i < int'(XB); i++) begin
         send_byte(x[i*BW +: BW]);
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int i = 0; i < int'(YB); i++) begin
         send_byte(y[i*BW +: BW]);
         if (gaps && i != int'(YB) - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic xfer_out_byte(input bit stall, output logic [BW-1:0] b);
      int t = 0;
      @(negedge clk);
      while (!out_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL recv_timeout: out_valid=%0b required 1 within 200 cycles", out_valid);
      end
      if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
      b = out_data;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic recv_product(input bit stall, output logic [PW-1:0] p);
      logic [BW-1:0] b;
      p = '0;
      for (int k = 0; k < int'(PB); k++) begin
         xfer_out_byte(stall, b);
         p[k*BW +: BW] = b;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef MULU_IO_RDY_EN
      mul_rdy = 1'b1;
`endif
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0 || mul_x !== '0 || mul_y !== '0) begin
         errors++;
         $display("FAIL reset_in: in_ready=%0b out_valid=%0b busy=%0b out_data=%h x=%h y=%h required 1 0 0 00 0000 0000",
                  in_ready, out_valid, busy, out_data, mul_x, mul_y);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_out: in_ready=%0b out_valid=%0b busy=%0b out_data=%h required 1 0 0 00",
                  in_ready, out_valid, busy, out_data);
      end
   endtask

   task automatic test_basic;
      logic [PW-1:0] p;
      send_ops(16'h1234, 16'h5678, 1'b0);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || mul_x !== 16'h1234 || mul_y !== 16'h5678) begin
         errors++;
         $display("FAIL basic_compute: busy=%0b in_ready=%0b x=%h y=%h required 1 0 1234 5678",
                  busy, in_ready, mul_x, mul_y);
      end
      recv_product(1'b0, p);
      checks++;
      if (p !== 32'h06260060) begin
         errors++;
         $display("FAIL basic_product: got %h required 06260060", p);
      end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_idle: busy=%0b out_valid=%0b in_ready=%0b required 0 0 1", busy, out_valid, in_ready);
      end
   endtask

   task automatic test_max;
      logic [PW-1:0] p;
      send_ops(16'hFFFF, 16'hFFFF, 1'b0);
      recv_product(1'b0, p);
      checks++;
      if (p !== 32'hFFFE0001) begin
         errors++;
         $display("FAIL max_product: got %h required fffe0001", p);
      end
      send_ops(16'h0000, 16'hABCD, 1'b0);
      recv_product(1'b0, p);
      checks++;
      if (p !== 32'h0) begin
         errors++;
         $display("FAIL zero_product: got %h required 00000000", p);
      end
   endtask

   task automatic test_backpressure;
      logic [PW-1:0] exp_p;
      logic [PW-1:0] p;
      logic [BW-1:0] b;
      exp_p = 32'(64'(16'hBEEF) * 64'(16'h1357));
      send_ops(16'hBEEF, 16'h1357, 1'b0);
      p = '0;
      for (int k = 0; k < 2; k++) begin
         xfer_out_byte(1'b0, b);
         p[k*BW +: BW] = b;
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_p[2*BW +: BW]) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d out_valid=%0b out_data=%h required 1 %h",
                     c, out_valid, out_data, exp_p[2*BW +: BW]);
         end
      end
      for (int k = 2; k < int'(PB); k++) begin
         xfer_out_byte(1'b0, b);
         p[k*BW +: BW] = b;
      end
      checks++;
      if (p !== exp_p) begin
         errors++;
         $display("FAIL bp_product: got %h required %h", p, exp_p);
      end
   endtask

   task automatic test_gaps;
      logic [PW-1:0] p;
      send_byte(8'h34);
      @(negedge clk); @(negedge clk);
      send_byte(8'h12);
      @(negedge clk);
      send_byte(8'h78);
      @(negedge clk); @(negedge clk); @(negedge clk);
      send_byte(8'h56);
      recv_product(1'b0, p);
      checks++;
      if (p !== 32'h06260060) begin
         errors++;
         $display("FAIL gaps_product: got %h required 06260060", p);
      end
   endtask

   task automatic test_illegal;
      logic [PW-1:0] p;
      send_ops(16'h00FF, 16'h0101, 1'b0);
      @(negedge clk);
      in_data = 8'hAA;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0 || mul_x !== 16'h00FF) begin
         errors++;
         $display("FAIL illegal_ready: in_ready=%0b x=%h required 0 00ff", in_ready, mul_x);
      end
      recv_product(1'b0, p);
      in_valid = 1'b0;
      checks++;
      if (p !== 32'h0000FFFF) begin
         errors++;
         $display("FAIL illegal_product: got %h required 0000ffff", p);
      end
      send_ops(16'h0003, 16'h0005, 1'b0);
      recv_product(1'b0, p);
      checks++;
      if (p !== 32'd15) begin
         errors++;
         $display("FAIL illegal_next: got %h required 0000000f", p);
      end
   endtask

   task automatic test_reset_mid;
      logic [PW-1:0] p;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (mul_x !== '0 || mul_y !== '0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: x=%h y=%h in_ready=%0b busy=%0b out_valid=%0b required 0000 0000 1 0 0",
                  mul_x, mul_y, in_ready, busy, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_ops(16'h0002, 16'h0003, 1'b0);
      recv_product(1'b0, p);
      checks++;
      if (p !== 32'd6) begin
         errors++;
         $display("FAIL midreset_product: got %h required 00000006", p);
      end
   endtask

   task automatic test_capture;
      logic [PW-1:0] p;
`ifdef MULU_IO_RDY_EN
      mul_rdy = 1'b0;
      send_ops(16'h0007, 16'h0009, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL capture_early: cycle %0d out_valid=%0b busy=%0b required 0 1", c, out_valid, busy);
         end
      end
      @(negedge clk);
      mul_rdy = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL capture_edge: out_valid=%0b required 1", out_valid);
      end
`else
      send_ops(16'h0007, 16'h0009, 1'b0);
      for (int c = 0; c < int'(LAT); c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL capture_early: cycle %0d out_valid=%0b busy=%0b required 0 1", c, out_valid, busy);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd63) begin
         errors++;
         $display("FAIL capture_edge: out_valid=%0b out_data=%h required 1 3f", out_valid, out_data);
      end
`endif
      recv_product(1'b0, p);
      checks++;
      if (p !== 32'd63) begin
         errors++;
         $display("FAIL capture_product: got %h required 0000003f", p);
      end
   endtask

   task automatic test_random;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [PW-1:0] p;
      logic [63:0]   exp_p;
      for (int n = 0; n < 30; n++) begin
         x = XW'($urandom);
         y = YW'($urandom);
         exp_p = 64'(x) * 64'(y);
         send_ops(x, y, 1'b1);
         recv_product(1'b1, p);
         checks++;
         if (p !== exp_p[PW-1:0]) begin
            errors++;
            $display("FAIL random_product: x=%h y=%h got %h required %h", x, y, p, exp_p[PW-1:0]);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_basic;
      test_max;
      test_backpressure;
      test_gaps;
      test_illegal;
      test_reset_mid;
      test_capture;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
